// File: rtl/rename_alloc_ctrl.sv
// Rename-stage allocator: hands out in-order tags from a circular pool, drives both RAT write
// ports in the accept cycle, flags intra-group RAW, and registers the group for dispatch.
package uarch_pkg;
    parameter int unsigned ARCH_REGS = 32;
    parameter int unsigned TAG_WIDTH = 5;
    localparam int unsigned RegW = $clog2(ARCH_REGS);

    typedef struct packed {
        logic                 we;
        logic [RegW-1:0]      addr;
        logic [TAG_WIDTH-1:0] tag;
    } prf_rat_write_port_t;
endpackage

module rename_alloc_ctrl #(
    parameter int unsigned NUM_TAGS  = 2 ** uarch_pkg::TAG_WIDTH,
    parameter int unsigned ARCH_REGS = uarch_pkg::ARCH_REGS
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               dec_valid_i,
    output logic                               dec_ready_o,
    input  logic                               i0_valid_i,
    input  logic                               i1_valid_i,
    input  logic [$clog2(ARCH_REGS)-1:0]       i0_rd_i,
    input  logic [$clog2(ARCH_REGS)-1:0]       i1_rd_i,
    input  logic                               i0_rd_we_i,
    input  logic                               i1_rd_we_i,
    input  logic [$clog2(ARCH_REGS)-1:0]       i1_rs1_i,
    input  logic [$clog2(ARCH_REGS)-1:0]       i1_rs2_i,
    output uarch_pkg::prf_rat_write_port_t     rat_0_write_port_o,
    output uarch_pkg::prf_rat_write_port_t     rat_1_write_port_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               out_i0_valid_o,
    output logic                               out_i1_valid_o,
    output logic [uarch_pkg::TAG_WIDTH-1:0]    out_tag0_o,
    output logic [uarch_pkg::TAG_WIDTH-1:0]    out_tag1_o,
    output logic                               out_i1_rs1_dep_o,
    output logic                               out_i1_rs2_dep_o,
    input  logic [1:0]                         commit_count_i,
    output logic [$clog2(NUM_TAGS):0]          free_count_o
);
    localparam int unsigned TagW = uarch_pkg::TAG_WIDTH;
    localparam int unsigned FcW  = $clog2(NUM_TAGS) + 1;

    logic [TagW-1:0] alloc_ptr_q, alloc_ptr_d, head_ptr_q, head_ptr_d;
    logic [FcW-1:0]  free_count_q, free_count_d;
    logic            out_valid_q, out_valid_d;
    logic            out_i0_valid_q, out_i0_valid_d, out_i1_valid_q, out_i1_valid_d;
    logic [TagW-1:0] out_tag0_q, out_tag0_d, out_tag1_q, out_tag1_d;
    logic            out_dep1_q, out_dep1_d, out_dep2_q, out_dep2_d;

    logic [FcW-1:0]  occupancy, commit_eff, n_alloc;
    logic [TagW-1:0] tag0, tag1;
    logic            fire, i0_dst, i1_waw, rat0_we, rat1_we, dep1, dep2;

    always_comb begin
        occupancy   = FcW'(NUM_TAGS) - free_count_q;
        // Retiring more tags than are outstanding would push free_count past the pool size.
        commit_eff  = (FcW'(commit_count_i) > occupancy) ? occupancy : FcW'(commit_count_i);
        dec_ready_o = !rst_i && !flush_i && (free_count_q >= FcW'(2))
                      && (!out_valid_q || out_ready_i);
        fire        = dec_valid_i && dec_ready_o;
        n_alloc     = fire ? (FcW'(i0_valid_i) + FcW'(i1_valid_i)) : '0;
        tag0        = alloc_ptr_q;
        tag1        = alloc_ptr_q + TagW'(1);
        i0_dst      = i0_valid_i && i0_rd_we_i && (i0_rd_i != '0);
        i1_waw      = i1_valid_i && i1_rd_we_i && (i1_rd_i == i0_rd_i);
        rat0_we     = fire && i0_dst && !i1_waw;
        rat1_we     = fire && i1_valid_i && i1_rd_we_i && (i1_rd_i != '0);
        dep1        = i1_valid_i && i0_dst && (i1_rs1_i == i0_rd_i);
        dep2        = i1_valid_i && i0_dst && (i1_rs2_i == i0_rd_i);

        rat_0_write_port_o.we   = rat0_we;
        rat_0_write_port_o.addr = rat0_we ? i0_rd_i : '0;
        rat_0_write_port_o.tag  = rat0_we ? tag0 : '0;
        rat_1_write_port_o.we   = rat1_we;
        rat_1_write_port_o.addr = rat1_we ? i1_rd_i : '0;
        rat_1_write_port_o.tag  = rat1_we ? tag1 : '0;
    end

    always_comb begin
        alloc_ptr_d    = alloc_ptr_q;
        head_ptr_d     = head_ptr_q;
        free_count_d   = free_count_q;
        out_valid_d    = out_valid_q;
        out_i0_valid_d = out_i0_valid_q;
        out_i1_valid_d = out_i1_valid_q;
        out_tag0_d     = out_tag0_q;
        out_tag1_d     = out_tag1_q;
        out_dep1_d     = out_dep1_q;
        out_dep2_d     = out_dep2_q;
        if (flush_i) begin
            alloc_ptr_d  = '0;
            head_ptr_d   = '0;
            free_count_d = FcW'(NUM_TAGS);
            out_valid_d  = 1'b0;
        end else begin
            alloc_ptr_d  = alloc_ptr_q + TagW'(n_alloc);
            head_ptr_d   = head_ptr_q + TagW'(commit_eff);
            free_count_d = free_count_q + commit_eff - n_alloc;
            if (fire) begin
                out_valid_d    = 1'b1;
                out_i0_valid_d = i0_valid_i;
                out_i1_valid_d = i1_valid_i;
                out_tag0_d     = i0_valid_i ? tag0 : '0;
                out_tag1_d     = i1_valid_i ? tag1 : '0;
                out_dep1_d     = dep1;
                out_dep2_d     = dep2;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_ptr_q    <= '0;
            head_ptr_q     <= '0;
            free_count_q   <= FcW'(NUM_TAGS);
            out_valid_q    <= 1'b0;
            out_i0_valid_q <= 1'b0;
            out_i1_valid_q <= 1'b0;
            out_tag0_q     <= '0;
            out_tag1_q     <= '0;
            out_dep1_q     <= 1'b0;
            out_dep2_q     <= 1'b0;
        end else begin
            alloc_ptr_q    <= alloc_ptr_d;
            head_ptr_q     <= head_ptr_d;
            free_count_q   <= free_count_d;
            out_valid_q    <= out_valid_d;
            out_i0_valid_q <= out_i0_valid_d;
            out_i1_valid_q <= out_i1_valid_d;
            out_tag0_q     <= out_tag0_d;
            out_tag1_q     <= out_tag1_d;
            out_dep1_q     <= out_dep1_d;
            out_dep2_q     <= out_dep2_d;
        end
    end

    assign free_count_o     = free_count_q;
    assign out_valid_o      = out_valid_q;
    assign out_i0_valid_o   = out_i0_valid_q;
    assign out_i1_valid_o   = out_i1_valid_q;
    assign out_tag0_o       = out_tag0_q;
    assign out_tag1_o       = out_tag1_q;
    assign out_i1_rs1_dep_o = out_dep1_q;
    assign out_i1_rs2_dep_o = out_dep2_q;
endmodule

// File: doc/rename_alloc_ctrl.md
# rename_alloc_ctrl

Rename-stage controller that sequences the physical register file's tag-write ports. It accepts a decoded 2-wide instruction group, allocates in-order tags (ROB slots) from a circular pool, and drives both RAT write ports. It detects intra-group dependencies, returns freed tags on commit, and presents the renamed group to dispatch through a registered valid/ready stage. It sits between decode and dispatch, alongside the PRF.

## Interface
Parameters:
- NUM_TAGS, default 2**TAG_WIDTH: tag pool size; a power of two.
- ARCH_REGS, default from uarch_pkg (32): architectural register count.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- flush, in, 1: synchronous pipeline flush.
- dec_valid, in, 1: decode group valid.
- dec_ready, out, 1: group accepted this cycle when dec_valid is also high.
- i0_valid, i1_valid, in, 1 each: per-slot valid. Slot 1 is valid only if slot 0 is valid.
- i0_rd, i1_rd, in, clog2(ARCH_REGS) each: destination registers.
- i0_rd_we, i1_rd_we, in, 1 each: destination-write enables.
- i1_rs1, i1_rs2, in, clog2(ARCH_REGS) each: slot-1 sources.
- rat_0_write_port, rat_1_write_port, out, prf_rat_write_port_t: {we, addr, tag} to the PRF.
- out_valid, out, 1: renamed group valid to dispatch.
- out_ready, in, 1: dispatch accepts.
- out_i0_valid, out_i1_valid, out, 1 each: registered slot valids.
- out_tag0, out_tag1, out, TAG_WIDTH each: allocated tags.
- out_i1_rs1_dep, out_i1_rs2_dep, out, 1 each: slot-1 source equals slot-0 rd; dispatch substitutes out_tag0.
- commit_count, in, 2: tags retired in order this cycle, 0..2.
- free_count, out, clog2(NUM_TAGS)+1: free tags.

## Operation
- State:
  - alloc_ptr: next tag to allocate.
  - head_ptr: oldest allocated tag.
  - free_count.
  - Output register: out_valid plus all out_* fields.
- Pointers are TAG_WIDTH wide and wrap modulo NUM_TAGS with no special case.
- Accept condition: fire = dec_valid & dec_ready.
  - dec_ready = !rst & !flush & (free_count >= 2) & (!out_valid | out_ready).
  - dec_ready never depends on the slot valids; two free tags are always required.
- Tag allocation on fire:
  - Slot 0 gets alloc_ptr if i0_valid.
  - Slot 1 gets alloc_ptr+1 if i1_valid.
  - alloc_ptr advances by i0_valid+i1_valid.
  - Every valid slot consumes a tag regardless of rd_we.
- RAT writes are combinational and asserted only in the fire cycle, so the PRF updates on the same edge that registers the group.
  - rat_0 we = fire & i0_valid & i0_rd_we & (i0_rd != 0) & !(i1_valid & i1_rd_we & i1_rd == i0_rd). This is WAW suppression: slot 1 wins.
  - rat_1 we = fire & i1_valid & i1_rd_we & (i1_rd != 0).
  - addr = the slot's rd; tag = the slot's allocated tag.
  - When we=0, addr and tag are 0.
- Dependency flag: out_i1_rs1_dep is registered as i1_valid & i0_valid & i0_rd_we & (i0_rd != 0) & (i1_rs1 == i0_rd). out_i1_rs2_dep uses the same logic with i1_rs2.
- Commit:
  - head_ptr += commit_count.
  - free_count += commit_count − allocated_this_cycle.
  - commit_count is clamped to the occupancy (NUM_TAGS − free_count), so free_count never exceeds NUM_TAGS.
- Output stage:
  - On fire, load all out_* fields and set out_valid=1.
  - Otherwise, if out_ready, clear out_valid.
  - While out_valid & !out_ready, all out_* fields hold stable.
- Flush (has priority over commit and fire):
  - Next cycle: alloc_ptr=0, head_ptr=0, free_count=NUM_TAGS, out_valid=0.
  - No RAT writes occur in the flush cycle.
  - The PRF clears its own renamed bits.

## Timing
- Reset values (applied asynchronously):
  - alloc_ptr=0, head_ptr=0, free_count=NUM_TAGS.
  - out_valid=0, all out_* fields=0.
  - dec_ready=0 while rst is high.
- Latency: a group fired at edge E appears on out_* immediately after E. The PRF tag/renamed state is also updated at E.
- Tags freed by commit at edge E count toward dec_ready in the cycle after E. They are never reused in the same cycle.
- Fire and commit in the same cycle both apply to free_count.
- Full throughput is one group per cycle while out_ready=1 and free_count >= 2.
- Reset deasserted mid-stream: the block restarts from the reset state, and the first tag issued is 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> free_count=NUM_TAGS (32), out_valid=0. After release, dec_ready=1.
- Back-to-back groups: two 2-slot groups (rd 3/4, then 5/6), out_ready=1 -> tags 0,1 then 2,3. rat writes {3,0},{4,1} then {5,2},{6,3}. free_count=28.
- Dependency and WAW:
  - i0 rd=5 with i1 rs1=5 -> out_i1_rs1_dep=1, out_i1_rs2_dep=0.
  - i0 rd=7 and i1 rd=7 -> rat_0 we=0, rat_1 we=1 with tag1.
  - rd=0 -> no write.
- Full and wrap: 16 groups with no commit -> free_count=0, dec_ready=0. Then commit_count=2 -> free_count=2 and dec_ready=1 the next cycle. Next tags are 0,1 (wrap).
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_* stable, dec_ready=0, rat we=0, alloc_ptr unchanged.
- Flush: flush with out_valid=1, free_count=20, and commit_count=2 in the same cycle -> free_count=32, out_valid=0. The next group receives tags 0,1.
